mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the CPU instruction-fetch path (IF),
//  data path (lw/lhu/sw in sMEM) and a debug/loader port (DBG). Each requester
//  gets one transaction at a time on a req/done handshake. A variable-latency
//  memory is driven over an m_req/m_ack handshake. A watchdog ends hung accesses.
// PARAMETERS
//  ADDR_W   32  address width, all ports
//  DATA_W   32  data width, all ports
//  STARVE   8   cycles DBG may wait while losing arbitration before it gets top priority
//  TIMEOUT  15  cycles in BUSY without m_ack before the access is aborted
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  if_req     in   1       fetch request (read only); level, held until if_done
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetch data, valid while if_done=1
//  if_done    out  1       1-cycle completion pulse
//  d_req      in   1       data request; level, held until d_done
//  d_we       in   1       1=write (sw), 0=read
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid while d_done=1
//  d_done     out  1       1-cycle completion pulse
//  dbg_req/dbg_we/dbg_addr/dbg_wdata in; dbg_rdata/dbg_done out -- same as d_*
//  m_req      out  1       memory access strobe, held until m_ack or abort
//  m_we       out  1       memory write enable, qualified by m_req
//  m_addr     out  ADDR_W  memory address
//  m_wdata    out  DATA_W  memory write data
//  m_rdata    in   DATA_W  memory read data, valid with m_ack
//  m_ack      in   1       memory completion; ignored unless m_req=1
//  busy       out  1       1 in BUSY and RESP
//  timeout_err out 1       sticky; set on any abort, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: m_*, *_done, *_rdata, busy, timeout_err.
//   Starve and watchdog counters=0. Reset mid-access drops m_req next edge, no done pulse.
//  FSM IDLE->BUSY->RESP->IDLE; one outstanding transaction.
//   IDLE: sample reqs; any req -> register winner (owner, we, addr, wdata) -> BUSY.
//   BUSY: m_req=1 with registered owner fields. m_ack=1 -> latch m_rdata -> RESP.
//         Watchdog reaches TIMEOUT -> rdata=0, set timeout_err -> RESP.
//   RESP: owner's *_done=1 for exactly this cycle, *_rdata=latched value; reqs ignored.
//         Other requesters' *_rdata hold their old values. -> IDLE.
//  Priority in IDLE: DBG if starve counter >= STARVE, else D > IF > DBG.
//  Starve counter: +1 on each IDLE arbitration DBG loses while dbg_req=1.
//   Clears when DBG wins or dbg_req=0. Saturates at STARVE.
//  Watchdog: clears on entry to BUSY, +1 each BUSY cycle without m_ack.
//   Abort occurs on the TIMEOUT-th such cycle.
//  Latency: req seen in IDLE at cycle 0, m_req at 1, m_ack at 1 earliest, done at 2.
//   Back-to-back grants are 3 cycles apart minimum.
//  Requesters must deassert req in the cycle their done is high. If req is still
//   high in the following IDLE, it is a new transaction.
//  m_ack together with watchdog expiry: the ack wins; no error.
//  Write completion: done pulses; *_rdata = m_rdata as latched (don't-care to requester).
//  Request fields must not change while req=1. They are sampled only in IDLE.
// TESTING
//  1 reset; if_req=1 addr=0x0 ; m_ack same cycle as m_req -> m_req cycle1, if_done cycle2, if_rdata=m_rdata
//  2 if_req,d_req both 1 in IDLE -> D served first (m_addr=d_addr); IF granted in next IDLE; no lost req
//  3 d_req held continuously, dbg_req=1 -> DBG granted after 8 lost arbitrations; starve counter resets
//  4 d_req write, m_ack never -> m_req high 15 cycles, d_done pulses, d_rdata=0, timeout_err=1 until reset
//  5 reset asserted while BUSY -> next cycle m_req=0, no done, state IDLE, timeout_err=0
//  6 m_ack on 15th BUSY cycle -> normal completion, timeout_err stays 0

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one variable-latency memory between fetch, data and debug ports.
// One outstanding transaction (IDLE -> BUSY -> RESP), starvation boost for debug, watchdog abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STARVE  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy,
  output logic              timeout_err
);

  localparam int SW = $clog2(STARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_D, OWN_DBG} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, win;
  logic              we_q, win_we;
  logic [ADDR_W-1:0] addr_q, win_addr;
  logic [DATA_W-1:0] wdata_q, win_wdata;
  logic [SW-1:0]     starve_q;
  logic [TW-1:0]     wd_q;
  logic              any_req, abort, finish;
  logic [DATA_W-1:0] resp_data;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q, dbg_rdata_q;
  logic              timeout_err_q;

  assign any_req = if_req | d_req | dbg_req;

  // Winner selection: a starved debug port jumps ahead, otherwise D > IF > DBG.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win       = OWN_IF;
    win_we    = 1'b0;
    win_addr  = if_addr;
    win_wdata = '0;
    if (dbg_req && (starve_q >= SW'(STARVE))) begin
      win = OWN_DBG; win_we = dbg_we; win_addr = dbg_addr; win_wdata = dbg_wdata;
    end else if (d_req) begin
      win = OWN_D; win_we = d_we; win_addr = d_addr; win_wdata = d_wdata;
    end else if (!if_req && dbg_req) begin
      win = OWN_DBG; win_we = dbg_we; win_addr = dbg_addr; win_wdata = dbg_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    abort     = 1'b0;
    finish    = 1'b0;
    resp_data = m_rdata;
    case (state_q)
      S_IDLE: if (any_req) state_d = S_BUSY;
      S_BUSY: begin
        // An ack arriving on the final watchdog cycle still completes normally.
        if (m_ack) begin
          finish  = 1'b1;
          state_d = S_RESP;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          finish    = 1'b1;
          resp_data = '0;
          state_d   = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_IF;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      starve_q      <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && any_req) begin
        owner_q <= win;
        we_q    <= win_we;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        wd_q    <= '0;
      end

      if (state_q == S_BUSY && !finish) wd_q <= wd_q + 1'b1;
      if (abort) timeout_err_q <= 1'b1;

      if (finish) begin
        case (owner_q)
          OWN_IF:  if_rdata_q  <= resp_data;
          OWN_D:   d_rdata_q   <= resp_data;
          OWN_DBG: dbg_rdata_q <= resp_data;
          default: ;
        endcase
      end

      // Starvation count tracks only consecutive arbitrations lost by a waiting debug port.
      if (!dbg_req) begin
        starve_q <= '0;
      end else if (state_q == S_IDLE) begin
        if (win == OWN_DBG)              starve_q <= '0;
        else if (starve_q < SW'(STARVE)) starve_q <= starve_q + 1'b1;
      end
    end
  end

  assign m_req       = (state_q == S_BUSY);
  assign m_we        = m_req & we_q;
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign if_done     = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign d_done      = (state_q == S_RESP) && (owner_q == OWN_D);
  assign dbg_done    = (state_q == S_RESP) && (owner_q == OWN_DBG);
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign dbg_rdata   = dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small latency-programmable memory responder.
// Outputs are sampled 1 time unit after the rising edge; the responder acts on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, dbg_req, dbg_we;
  logic [31:0] if_addr, d_addr, d_wdata, dbg_addr, dbg_wdata;
  logic [31:0] if_rdata, d_rdata, dbg_rdata;
  logic        if_done, d_done, dbg_done;
  logic        m_req, m_we, busy, timeout_err;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack   = 1'b0;

  int          ack_lat   = 0;
  logic        ack_never = 1'b0;
  int          req_cycles = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory responder: acks on the (ack_lat+1)-th cycle of m_req unless ack_never is set.
  always @(negedge clk) begin
    if (m_req) begin
      m_ack   = !ack_never && (req_cycles == ack_lat);
      m_rdata = model(m_addr);
      if (m_ack && m_we) begin
        last_waddr = m_addr;
        last_wdata = m_wdata;
      end
      req_cycles++;
    end else begin
      m_ack      = 1'b0;
      req_cycles = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_d, n_m;
  logic got;

  initial begin
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; dbg_req = 0; dbg_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    check("rst_m_req", m_req, 0);
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);
    check("rst_dones", {if_done, d_done, dbg_done}, 0);
    check("rst_rdata", if_rdata | d_rdata | dbg_rdata, 0);
    check("rst_m_addr", m_addr, 0);
    reset = 1'b0;

    // 1: fetch with zero-latency ack
    if_req = 1; if_addr = 32'h0;
    tick();
    check("t1_m_req_c1", m_req, 1);
    check("t1_m_addr", m_addr, 32'h0);
    check("t1_no_done_c1", if_done, 0);
    tick();
    check("t1_if_done_c2", if_done, 1);
    check("t1_if_rdata", if_rdata, model(32'h0));
    check("t1_m_req_drop", m_req, 0);
    if_req = 0;
    tick();
    check("t1_done_pulse", if_done, 0);
    check("t1_idle", busy, 0);

    // 2: simultaneous IF and D, D first, IF not lost
    if_req = 1; if_addr = 32'h100;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    check("t2_d_first_addr", m_addr, 32'h200);
    tick();
    check("t2_d_done", d_done, 1);
    check("t2_if_not_done", if_done, 0);
    check("t2_d_rdata", d_rdata, model(32'h200));
    d_req = 0;
    tick();
    check("t2_idle_gap", busy, 0);
    tick();
    check("t2_if_grant_addr", m_addr, 32'h100);
    tick();
    check("t2_if_done", if_done, 1);
    check("t2_if_rdata", if_rdata, model(32'h100));
    check("t2_d_rdata_hold", d_rdata, model(32'h200));
    if_req = 0;
    tick();

    // 3: D held continuously, DBG wins after 8 losses; counter restarts afterwards
    for (int round = 0; round < 2; round++) begin
      d_req = 1; d_we = 0; d_addr = 32'h300;
      dbg_req = 1; dbg_addr = 32'h400 + round; dbg_we = (round == 1);
      dbg_wdata = 32'h1234_5678;
      n_d = 0; got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
        tick();
        if (d_done) n_d++;
        if (dbg_done) begin
          got = 1;
          dbg_req = 0;
        end
      end
      check("t3_dbg_granted", got, 1);
      check("t3_d_wins_before_dbg", n_d, 8);
      if (round == 0) check("t3_dbg_rdata", dbg_rdata, model(32'h400));
    end
    check("t3_dbg_write_addr", last_waddr, 32'h401);
    check("t3_dbg_write_data", last_wdata, 32'h1234_5678);
    d_req = 0;
    tick(); tick();

    // 4: write with no ack -> watchdog abort after 15 m_req cycles
    ack_never = 1;
    d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("t4_m_we", m_we, 1);
    check("t4_m_wdata", m_wdata, 32'hDEAD_BEEF);
    n_m = m_req ? 1 : 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (d_done) got = 1;
      else if (m_req) n_m++;
    end
    check("t4_done_seen", got, 1);
    check("t4_m_req_cycles", n_m, 15);
    check("t4_d_rdata_zero", d_rdata, 0);
    check("t4_err_set", timeout_err, 1);
    d_req = 0; d_we = 0;
    ack_never = 0;
    tick(); tick(); tick();
    check("t4_err_sticky", timeout_err, 1);

    // 5: reset while BUSY
    ack_never = 1;
    d_req = 1; d_addr = 32'h700;
    tick(); tick(); tick();
    check("t5_busy_before", m_req, 1);
    reset = 1;
    tick();
    check("t5_m_req_drop", m_req, 0);
    check("t5_no_done", d_done, 0);
    check("t5_idle", busy, 0);
    check("t5_err_cleared", timeout_err, 0);
    check("t5_rdata_cleared", d_rdata, 0);
    reset = 0; d_req = 0; ack_never = 0;
    tick();
    check("t5_no_late_done", d_done, 0);

    // 6: ack on the 15th BUSY cycle completes normally
    ack_lat = 14;
    d_req = 1; d_we = 0; d_addr = 32'h600;
    tick();
    n_m = m_req ? 1 : 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (d_done) got = 1;
      else if (m_req) n_m++;
    end
    check("t6_done_seen", got, 1);
    check("t6_m_req_cycles", n_m, 15);
    check("t6_no_err", timeout_err, 0);
    check("t6_d_rdata", d_rdata, model(32'h600));
    d_req = 0; ack_lat = 0;
    tick(); tick();
    check("t6_err_still_clear", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

endmodule
